// File: rtl/priority_scan_stream_if.sv
// Handshake bundle for priority_scan_stream: vector-in stream and index-out stream.
// The slave modport is the scanner's view; master is the producer/consumer side.
interface priority_scan_stream_if #(
   parameter int VWIDTH = 32,
   parameter int AWIDTH = (VWIDTH == 1) ? 1 : $clog2(VWIDTH),
   parameter int IWIDTH = (VWIDTH == 1) ? 1 : $clog2(VWIDTH)
);
   logic              in_valid;
   logic              in_ready;
   logic [VWIDTH-1:0] in_vector;
   logic              in_dir;
   logic              in_val;
   logic              out_valid;
   logic              out_ready;
   logic [AWIDTH-1:0] out_addr;
   logic [IWIDTH-1:0] out_index;
   logic              out_last;
   logic              out_none;
   logic              out_trunc;

   modport slave (
      input  in_valid, in_vector, in_dir, in_val, out_ready,
      output in_ready, out_valid, out_addr, out_index, out_last, out_none, out_trunc
   );

   modport master (
      output in_valid, in_vector, in_dir, in_val, out_ready,
      input  in_ready, out_valid, out_addr, out_index, out_last, out_none, out_trunc
   );
endinterface

// File: rtl/priority_scan_stream.sv
// Streaming priority scanner: accepts a vector, then emits each matching bit
// position as one output beat, in a runtime-selected direction, capped at MAX_HITS.
module priority_scan_stream #(
   parameter int VWIDTH   = 32,
   parameter int AWIDTH   = (VWIDTH == 1) ? 1 : $clog2(VWIDTH),
   parameter int MAX_HITS = VWIDTH,
   parameter int IWIDTH   = (MAX_HITS == 1) ? 1 : $clog2(MAX_HITS)
) (
   input  logic                    clk,
   input  logic                    rst,
   priority_scan_stream_if.slave   bus,
   output logic                    busy
);
   localparam int LEVELS = (VWIDTH == 1) ? 0 : $clog2(VWIDTH);
   localparam int P      = 1 << LEVELS;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t            state_reg, state_next;
   logic [VWIDTH-1:0] work_reg, work_next;
   logic              dir_reg, dir_next;
   logic [IWIDTH-1:0] cnt_reg, cnt_next;

   logic [VWIDTH-1:0] scan_vec;
   logic [VWIDTH-1:0] hit_mask;
   logic [VWIDTH-1:0] rest;
   logic [AWIDTH-1:0] first_pos;
   logic [AWIDTH-1:0] hit_addr;
   logic              any_hit;
   logic              at_limit;
   logic              last_int;
   logic              in_scan;
   logic              beat_done;
   logic              accept;

   // Reversing the vector for msb-first lets one lowest-set-bit tree serve both directions.
   genvar gi;
   generate
      for (gi = 0; gi < VWIDTH; gi++) begin : g_rev
         assign scan_vec[gi] = dir_reg ? work_reg[VWIDTH-1-gi] : work_reg[gi];
      end
   endgenerate

   // Heap-ordered tree: leaves at P..2P-1, node n has children 2n (lower bits) and 2n+1.
   logic              node_v [1:2*P-1];
   logic [AWIDTH-1:0] node_i [1:2*P-1];

   generate
      for (gi = 0; gi < P; gi++) begin : g_leaf
         if (gi < VWIDTH) begin : g_real
            assign node_v[P+gi] = scan_vec[gi];
         end else begin : g_pad
            assign node_v[P+gi] = 1'b0;
         end
         assign node_i[P+gi] = AWIDTH'(gi);
      end
      for (gi = 1; gi < P; gi++) begin : g_node
         assign node_v[gi] = node_v[2*gi] | node_v[2*gi+1];
         assign node_i[gi] = node_v[2*gi] ? node_i[2*gi] : node_i[2*gi+1];
      end
   endgenerate

   assign first_pos = node_i[1];
   assign any_hit   = |work_reg;
   assign hit_addr  = dir_reg ? (AWIDTH'(VWIDTH - 1) - first_pos) : first_pos;
   assign hit_mask  = VWIDTH'(1) << hit_addr;
   assign rest      = work_reg & ~hit_mask;
   assign at_limit  = (cnt_reg == IWIDTH'(MAX_HITS - 1));

   assign in_scan   = (state_reg == SCAN);
   assign last_int  = !any_hit || (rest == '0) || at_limit;
   assign beat_done = in_scan && bus.out_ready;
   assign accept    = bus.in_valid && bus.in_ready;

   assign busy          = in_scan;
   assign bus.in_ready  = !in_scan || (beat_done && last_int);
   assign bus.out_valid = in_scan;
   assign bus.out_addr  = (in_scan && any_hit) ? hit_addr : '0;
   assign bus.out_index = in_scan ? cnt_reg : '0;
   assign bus.out_last  = in_scan && last_int;
   assign bus.out_none  = in_scan && !any_hit;
   assign bus.out_trunc = in_scan && any_hit && at_limit && (rest != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         work_reg  <= '0;
         dir_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         work_reg  <= work_next;
         dir_reg   <= dir_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      work_next  = work_reg;
      dir_next   = dir_reg;
      cnt_next   = cnt_reg;
      if (beat_done) begin
         work_next = rest;
         if (last_int) begin
            state_next = IDLE;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
      // A new vector wins over the retiring one when both land on the same edge.
      if (accept) begin
         state_next = SCAN;
         work_next  = bus.in_val ? bus.in_vector : ~bus.in_vector;
         dir_next   = bus.in_dir;
         cnt_next   = '0;
      end
   end
endmodule

// File: doc/priority_scan_stream.md
Name: priority_scan_stream

Overview:
- Streaming successor to the single-shot priority encoder.
- Accepts one vector per valid/ready handshake. Emits every matching bit position as a sequence of output beats, one per cycle when the consumer is ready.
- Search direction and search value are selectable per vector at runtime, not by parameter. A hit limit truncates long scans.
- Sits between request/status vectors (interrupt pending, free-slot maps) and consumers that service one index at a time.

Parameters:
- VWIDTH, 32: input vector width, at least 1.
- AWIDTH, (VWIDTH==1)?1:$clog2(VWIDTH): width of out_addr.
- MAX_HITS, VWIDTH: maximum beats emitted per vector, 1..VWIDTH.
- IWIDTH, (MAX_HITS==1)?1:$clog2(MAX_HITS): width of out_index.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_vector  in  VWIDTH  vector to scan
- in_dir  in  1  0: lsb to msb, 1: msb to lsb
- in_val  in  1  0: find zeros, 1: find ones
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_addr  out  AWIDTH  bit position of current hit
- out_index  out  IWIDTH  ordinal of hit within vector, starting at 0
- out_last  out  1  final beat for this vector
- out_none  out  1  vector had no match (single beat)
- out_trunc  out  1  on last beat only: further matches were dropped because of MAX_HITS
- busy  out  1  a vector is held (state SCAN)

Behaviour:
- Reset is rst, asynchronous, active-high; the clock is clk.
- Reset values: state IDLE, out_valid=0, out_addr=0, out_index=0, out_last=0, out_none=0, out_trunc=0, busy=0. in_ready=1 after reset releases.
- A reset mid-scan discards the held vector. No further beats are emitted for it.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: out_valid=1.
- Accept:
  - A vector is accepted when in_valid and in_ready are both high at a rising edge.
  - At accept, work <= in_val ? in_vector : ~in_vector. dir <= in_dir. hit count <= 0. State goes to SCAN.
- Latency: out_valid is asserted in the cycle after acceptance, i.e. one register stage.
- Beat contents in SCAN:
  - out_addr is the first set bit of work in the direction dir.
  - out_index is the current hit count.
  - If work==0: out_none=1, out_last=1, out_addr=0.
  - Otherwise: out_last=1 when clearing the current bit leaves work==0, or when the hit count equals MAX_HITS-1.
  - out_trunc=1 when out_last is caused by MAX_HITS while remaining work is nonzero.
- Handshake:
  - A beat completes when out_valid and out_ready are both high at a rising edge.
  - On completion, the current bit is cleared and the hit count increments.
  - On completion of a beat with out_last, state returns to IDLE.
  - While out_ready is low, every out_* signal holds stable. No beat is dropped or duplicated.
- Back-to-back vectors:
  - in_ready = IDLE, or (out_valid & out_ready & out_last).
  - If a new vector is accepted in the same cycle that the last beat completes, the block goes directly from SCAN to SCAN with no bubble.
- Throughput: one beat per cycle while out_ready is high.
- Input side: in_dir, in_val and in_vector are sampled only at accept. Changes while busy are ignored.
- Width rules:
  - out_addr ranges over 0..VWIDTH-1.
  - out_index never exceeds MAX_HITS-1.
  - The hit counter never wraps.
- VWIDTH=1 degenerates to a single beat with out_addr=0. The beat has out_none set if the bit does not match.
- The first-set-bit search is a log-depth tree, not a linear chain.

Test Plan:
- VWIDTH=8, vector 8'b0010_0110, val=1, dir=0, out_ready=1 → beats addr 1,2,5 with index 0,1,2. out_last on addr 5. out_valid first rises one cycle after accept.
- Same vector with dir=1 → addr 5,2,1. Then val=0, dir=0 → addr 0,3,4,6,7 with out_last on 7.
- val=1, vector 8'h00 → exactly one beat: out_none=1, out_last=1, out_addr=0, out_index=0. Then the block returns to IDLE.
- Backpressure: during the second beat, hold out_ready low for 3 cycles → addr=2 and index=1 held constant. Release → addr 5 follows, and no beat is skipped.
- MAX_HITS=2, vector 8'hF0, val=1, dir=0 → addr 4 then 5. The second beat has out_last=1 and out_trunc=1. A new vector presented during that beat is accepted in the same cycle.
- Assert rst while in SCAN after one beat → outputs zero immediately and in_ready=1 after release. The next vector 8'h01 yields a single beat with addr 0 and no stale beats.
